aux_sink_reply_ctrl: RTL and testbench
======================================

// Module: aux_sink_reply_ctrl
// PURPOSE
// Sink-side AUX native-transaction responder: the far end of the source AUX controller.
// Takes decoded request frames (header + write bytes + stop) from the sink request decoder.
// Services them against a local DPCD register window.
// Drives reply fields to the sink reply encoder: ACK/NACK/DEFER, read data, NACK written-count byte.
// PARAMETERS
// DPCD_BASE   20'h00100  first DPCD address served by the local window
// DPCD_DEPTH  16         number of byte registers in the window (2..256)
// REPLY_DLY   4          idle cycles between request stop and reply start (>=1)
// PORTS
// clk          in   1   clock
// rst          in   1   synchronous active-high reset
// req_hdr_vld  in   1   1-cycle pulse; req_cmd/req_address/req_len valid
// req_cmd      in   2   00 write, 01 read, 1x unsupported
// req_address  in   20  start DPCD address
// req_len      in   8   byte count minus 1
// req_data_vld in   1   write data byte valid
// req_data     in   8   write data byte
// req_stop     in   1   1-cycle pulse; end of request frame
// sink_busy    in   1   sink cannot service now; forces DEFER
// rsp_busy     out  1   high in every state except IDLE; headers then ignored
// rpl_tr_vld   out  1   1-cycle pulse; rpl_ack valid
// rpl_ack      out  2   00 ACK, 01 NACK, 10 DEFER
// rpl_data_vld out  1   reply data byte valid
// rpl_data     out  8   reply data byte
// rpl_done     out  1   1-cycle pulse; reply complete
// BEHAVIOUR
// Reset:
// - rst sampled on clk. All outputs, counters and window registers go to 0; state goes to IDLE.
// - Reset mid-transaction abandons the transaction; no rpl_done is issued.
// - All outputs are registered.
// State flow:
// - IDLE -> RX_WDATA when req_hdr_vld and cmd=00.
// - IDLE -> WAIT_STOP when req_hdr_vld and cmd!=00.
// - RX_WDATA / WAIT_STOP -> TURN on req_stop.
// - TURN -> TX_HDR after REPLY_DLY cycles.
// - TX_HDR -> TX_DATA or DONE.
// - TX_DATA -> DONE after the last byte.
// - DONE -> IDLE.
// Header latch:
// - cmd/address/len are captured on req_hdr_vld.
// - sink_busy is sampled in the same cycle; if high, the reply is DEFER.
// - A deferred write discards its data bytes; window unchanged.
// Range check:
// - end = address + len, computed in 21 bits with no wrap.
// - A byte is in range iff DPCD_BASE <= a <= DPCD_BASE+DPCD_DEPTH-1.
// Write (RX_WDATA):
// - Each req_data_vld byte i (0-based) writes window[address+i] in the same cycle.
// - Writing requires i <= len and address+i in range.
// - The first out-of-range byte freezes writing; wcnt = bytes actually written (9-bit counter).
// - Bytes beyond len+1 are ignored.
// Write reply:
// - ACK if wcnt = len+1.
// - Otherwise NACK plus one data byte = wcnt[7:0]. This covers short frames, out-of-range bytes and over-long frames.
// Read reply:
// - ACK if the whole range address..end is in range, followed by len+1 data bytes, 1 per cycle.
// - Data bytes are window[address], window[address+1], ...
// - Otherwise NACK with no data.
// Unsupported cmd (1x): NACK, no data.
// Reply timing:
// - TURN counts REPLY_DLY cycles from the cycle after req_stop.
// - rpl_tr_vld is high exactly one cycle in TX_HDR.
// - rpl_data_vld is contiguous starting the cycle after rpl_tr_vld.
// - rpl_done pulses the cycle after the last data byte, or the cycle after rpl_tr_vld if there is no data.
// Ignored inputs:
// - req_data_vld outside RX_WDATA.
// - req_stop in IDLE.
// - req_hdr_vld while rsp_busy.
// - Simultaneous req_hdr_vld and req_stop in IDLE: the header is taken and the stop is ignored.
// Other rules:
// - rpl_data is 0 whenever rpl_data_vld is low; rpl_ack is 0 when rpl_tr_vld is low.
// TESTING
// - Write hdr addr=0x00100, len=1, bytes A5,3C, stop; REPLY_DLY=4.
//   -> rpl_tr_vld 5 cycles after stop, ACK, no data, rpl_done next cycle.
// - Read back: addr=0x00100, len=1, stop.
//   -> ACK, then rpl_data A5,3C on consecutive cycles, then rpl_done.
// - Write addr=0x0010E, len=3, bytes 11,22,33,44.
//   -> window[E]=11, window[F]=22, NACK with data byte 02; 0x00110+ untouched.
// - Read addr=0x0010F, len=1.
//   -> NACK, no rpl_data_vld, rpl_done the cycle after rpl_tr_vld.
// - sink_busy=1 at write hdr addr=0x00100, len=0, byte FF.
//   -> DEFER; a subsequent read of 0x00100 returns the prior value.
// - rst=1 for one cycle during TX_DATA of a len=7 read.
//   -> the next cycle shows all outputs 0, rsp_busy 0, no rpl_done; window reads back 00.

Source files
------------

// File: rtl/aux_sink_reply_ctrl.sv
// Sink-side AUX native-transaction responder. Latches decoded request frames, services
// them against a local DPCD byte window, and drives registered reply fields to the encoder.
module aux_sink_reply_ctrl #(
  parameter logic [19:0] DPCD_BASE  = 20'h00100,
  parameter int unsigned DPCD_DEPTH = 16,
  parameter int unsigned REPLY_DLY  = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_hdr_vld,
  input  logic [1:0]  req_cmd,
  input  logic [19:0] req_address,
  input  logic [7:0]  req_len,
  input  logic        req_data_vld,
  input  logic [7:0]  req_data,
  input  logic        req_stop,
  input  logic        sink_busy,
  output logic        rsp_busy,
  output logic        rpl_tr_vld,
  output logic [1:0]  rpl_ack,
  output logic        rpl_data_vld,
  output logic [7:0]  rpl_data,
  output logic        rpl_done
);

  localparam int unsigned IDX_W    = (DPCD_DEPTH > 1) ? $clog2(DPCD_DEPTH) : 1;
  localparam logic [20:0] BASE21   = {1'b0, DPCD_BASE};
  localparam logic [20:0] LAST21   = BASE21 + 21'(DPCD_DEPTH) - 21'd1;
  localparam logic [15:0] DLY_LAST = 16'(REPLY_DLY - 1);

  localparam logic [1:0] AckAck   = 2'b00;
  localparam logic [1:0] AckNack  = 2'b01;
  localparam logic [1:0] AckDefer = 2'b10;

  typedef enum logic [2:0] {
    StIdle, StRxWdata, StWaitStop, StTurn, StTxHdr, StTxData, StDone
  } state_e;

  state_e state_q, state_d;

  logic [1:0]  cmd_q;
  logic [19:0] addr_q;
  logic [7:0]  len_q;
  logic        defer_q;
  logic        frozen_q;
  logic [8:0]  idx_q;   // write byte index within the frame, saturates at len+1
  logic [8:0]  wcnt_q;  // bytes actually written
  logic [15:0] dly_q;
  logic [8:0]  cnt_q;   // index of the reply byte currently on rpl_data
  logic [7:0]  window_q [DPCD_DEPTH];

  logic [20:0]      wr_a, rd_a, rd_end;
  logic             wr_in, wr_take, wr_en, rd_ok;
  logic [IDX_W-1:0] wr_idx, rd_idx;
  logic [1:0]       ack_code;
  logic [8:0]       nbytes, tx_idx;
  logic [7:0]       tx_byte;

  // Write-path decode and reply-content decision from the latched request.
  always_comb begin
    wr_a    = {1'b0, addr_q} + {12'b0, idx_q};
    wr_in   = (wr_a >= BASE21) && (wr_a <= LAST21);
    wr_take = (state_q == StRxWdata) && req_data_vld && (idx_q <= {1'b0, len_q});
    wr_en   = wr_take && !defer_q && !frozen_q && wr_in;
    wr_idx  = IDX_W'(wr_a - BASE21);

    rd_end  = {1'b0, addr_q} + {13'b0, len_q};
    rd_ok   = ({1'b0, addr_q} >= BASE21) && (rd_end <= LAST21);

    ack_code = AckAck;
    nbytes   = 9'd0;
    if (defer_q) begin
      ack_code = AckDefer;
    end else if (cmd_q[1]) begin
      ack_code = AckNack;
    end else if (cmd_q == 2'b00) begin
      if (wcnt_q != {1'b0, len_q} + 9'd1) begin
        ack_code = AckNack;
        nbytes   = 9'd1;
      end
    end else if (rd_ok) begin
      nbytes = {1'b0, len_q} + 9'd1;
    end else begin
      ack_code = AckNack;
    end

    tx_idx  = (state_q == StTxHdr) ? 9'd0 : cnt_q + 9'd1;
    rd_a    = {1'b0, addr_q} + {12'b0, tx_idx};
    rd_idx  = IDX_W'(rd_a - BASE21);
    tx_byte = (cmd_q == 2'b00) ? wcnt_q[7:0] : window_q[rd_idx];
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:     if (req_hdr_vld) state_d = (req_cmd == 2'b00) ? StRxWdata : StWaitStop;
      StRxWdata,
      StWaitStop: if (req_stop) state_d = StTurn;
      StTurn:     if (dly_q == DLY_LAST) state_d = StTxHdr;
      StTxHdr:    state_d = (nbytes != 9'd0) ? StTxData : StDone;
      StTxData:   if (cnt_q == nbytes - 9'd1) state_d = StDone;
      StDone:     state_d = StIdle;
      default:    state_d = StIdle;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state_q <= StIdle;
    else     state_q <= state_d;
  end

  // Header latch, write counters, turnaround delay and the DPCD window.
  always_ff @(posedge clk) begin
    if (rst) begin
      cmd_q    <= 2'b00;
      addr_q   <= 20'd0;
      len_q    <= 8'd0;
      defer_q  <= 1'b0;
      frozen_q <= 1'b0;
      idx_q    <= 9'd0;
      wcnt_q   <= 9'd0;
      dly_q    <= 16'd0;
      cnt_q    <= 9'd0;
      for (int i = 0; i < int'(DPCD_DEPTH); i++) window_q[i] <= 8'h00;
    end else begin
      if (state_q == StIdle && req_hdr_vld) begin
        cmd_q    <= req_cmd;
        addr_q   <= req_address;
        len_q    <= req_len;
        defer_q  <= sink_busy;
        frozen_q <= 1'b0;
        idx_q    <= 9'd0;
        wcnt_q   <= 9'd0;
      end
      if (wr_take) idx_q <= idx_q + 9'd1;
      if (wr_en) begin
        window_q[wr_idx] <= req_data;
        wcnt_q           <= wcnt_q + 9'd1;
      end else if (wr_take && !defer_q && !wr_in) begin
        frozen_q <= 1'b1;
      end
      dly_q <= (state_q == StTurn) ? dly_q + 16'd1 : 16'd0;
      if (state_d == StTxData) cnt_q <= tx_idx;
    end
  end

  // Registered reply outputs, driven from the next state so they line up with it.
  always_ff @(posedge clk) begin
    if (rst) begin
      rsp_busy     <= 1'b0;
      rpl_tr_vld   <= 1'b0;
      rpl_ack      <= 2'b00;
      rpl_data_vld <= 1'b0;
      rpl_data     <= 8'h00;
      rpl_done     <= 1'b0;
    end else begin
      rsp_busy     <= (state_d != StIdle);
      rpl_tr_vld   <= (state_d == StTxHdr);
      rpl_ack      <= (state_d == StTxHdr) ? ack_code : 2'b00;
      rpl_data_vld <= (state_d == StTxData);
      rpl_data     <= (state_d == StTxData) ? tx_byte : 8'h00;
      rpl_done     <= (state_d == StDone);
    end
  end

endmodule

// File: tb/tb_aux_sink_reply_ctrl.sv
// Scoreboard bench for aux_sink_reply_ctrl: directed request frames push expected reply
// events (with their exact cycle); an independent monitor pops and compares them.
`timescale 1ns/1ps
module tb_aux_sink_reply_ctrl;

  localparam int DLY = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_hdr_vld, req_data_vld, req_stop, sink_busy;
  logic [1:0]  req_cmd;
  logic [19:0] req_address;
  logic [7:0]  req_len, req_data;
  logic        rsp_busy, rpl_tr_vld, rpl_data_vld, rpl_done;
  logic [1:0]  rpl_ack;
  logic [7:0]  rpl_data;

  aux_sink_reply_ctrl #(
    .DPCD_BASE (20'h00100),
    .DPCD_DEPTH(16),
    .REPLY_DLY (DLY)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .req_hdr_vld (req_hdr_vld),
    .req_cmd     (req_cmd),
    .req_address (req_address),
    .req_len     (req_len),
    .req_data_vld(req_data_vld),
    .req_data    (req_data),
    .req_stop    (req_stop),
    .sink_busy   (sink_busy),
    .rsp_busy    (rsp_busy),
    .rpl_tr_vld  (rpl_tr_vld),
    .rpl_ack     (rpl_ack),
    .rpl_data_vld(rpl_data_vld),
    .rpl_data    (rpl_data),
    .rpl_done    (rpl_done)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // kind: 0 header (val = ack code), 1 data byte, 2 done
  typedef struct {
    int         kind;
    logic [7:0] val;
    int         cyc;
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_err = 0;
  logic mon_en = 1'b0;
  logic [7:0] wbuf [8];
  logic [7:0] ebuf [8];

  task automatic push(input int kind, input logic [7:0] val, input int c);
    exp_t e;
    e.kind = kind;
    e.val  = val;
    e.cyc  = c;
    exp_q.push_back(e);
  endtask

  task automatic check_item(input int kind, input logic [7:0] val);
    exp_t e;
    n_cmp++;
    if (exp_q.size() == 0) begin
      n_err++;
      $display("FAIL unexpected_output: got kind=%0d val=%02h cyc=%0d, required nothing",
               kind, val, cyc);
    end else begin
      e = exp_q.pop_front();
      if (e.kind != kind || e.val != val || e.cyc != cyc) begin
        n_err++;
        $display("FAIL reply_event: got kind=%0d val=%02h cyc=%0d, required kind=%0d val=%02h cyc=%0d",
                 kind, val, cyc, e.kind, e.val, e.cyc);
      end
    end
  endtask

  // Monitor: consumes every reply event and checks the zero-when-invalid rules.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (mon_en) begin
        if (rpl_tr_vld)   check_item(0, {6'b0, rpl_ack});
        if (rpl_data_vld) check_item(1, rpl_data);
        if (rpl_done)     check_item(2, 8'h00);
        n_cmp++;
        if ((!rpl_tr_vld && rpl_ack != 2'b00) || (!rpl_data_vld && rpl_data != 8'h00)) begin
          n_err++;
          $display("FAIL idle_zero: got ack=%0d data=%02h, required 0 when not valid",
                   rpl_ack, rpl_data);
        end
      end
    end
  end

  task automatic wait_until(input int c);
    while (cyc < c) begin
      @(posedge clk);
      #1;
    end
  endtask

  // One request frame; write bytes from wbuf, expected reply bytes from ebuf.
  task automatic run_txn(input logic [1:0] c, input logic [19:0] a, input logic [7:0] l,
                         input logic busy, input logic stop_with_hdr, input int nwr,
                         input logic [1:0] ack, input int nexp);
    int s;
    @(posedge clk);
    #1;
    req_hdr_vld = 1'b1;
    req_cmd     = c;
    req_address = a;
    req_len     = l;
    sink_busy   = busy;
    req_stop    = stop_with_hdr;
    @(posedge clk);
    #1;
    req_hdr_vld = 1'b0;
    sink_busy   = 1'b0;
    req_stop    = 1'b0;
    n_cmp++;
    if (rsp_busy !== 1'b1) begin
      n_err++;
      $display("FAIL busy_after_hdr: got %b, required 1", rsp_busy);
    end
    for (int i = 0; i < nwr; i++) begin
      req_data_vld = 1'b1;
      req_data     = wbuf[i];
      @(posedge clk);
      #1;
    end
    req_data_vld = 1'b0;
    req_data     = 8'h00;
    req_stop     = 1'b1;
    s = cyc;
    push(0, {6'b0, ack}, s + DLY + 1);
    for (int k = 0; k < nexp; k++) push(1, ebuf[k], s + DLY + 2 + k);
    push(2, 8'h00, s + DLY + 2 + nexp);
    @(posedge clk);
    #1;
    req_stop = 1'b0;
    wait_until(s + DLY + 3 + nexp);
    n_cmp++;
    if (rsp_busy !== 1'b0) begin
      n_err++;
      $display("FAIL busy_after_done: got %b, required 0", rsp_busy);
    end
  endtask

  initial begin
    int s;
    rst          = 1'b1;
    req_hdr_vld  = 1'b0;
    req_cmd      = 2'b00;
    req_address  = 20'h0;
    req_len      = 8'h0;
    req_data_vld = 1'b0;
    req_data     = 8'h00;
    req_stop     = 1'b0;
    sink_busy    = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    n_cmp++;
    if ({rsp_busy, rpl_tr_vld, rpl_ack, rpl_data_vld, rpl_data, rpl_done} !== 14'h0) begin
      n_err++;
      $display("FAIL reset_state: got busy=%b tr=%b ack=%0d dv=%b d=%02h done=%b, required all 0",
               rsp_busy, rpl_tr_vld, rpl_ack, rpl_data_vld, rpl_data, rpl_done);
    end
    rst    = 1'b0;
    mon_en = 1'b1;

    // Write A5,3C to 0x100..0x101 -> ACK
    wbuf[0] = 8'hA5; wbuf[1] = 8'h3C;
    run_txn(2'b00, 20'h00100, 8'd1, 1'b0, 1'b0, 2, 2'b00, 0);
    // Read them back
    ebuf[0] = 8'hA5; ebuf[1] = 8'h3C;
    run_txn(2'b01, 20'h00100, 8'd1, 1'b0, 1'b0, 0, 2'b00, 2);
    // Write straddling the top of the window -> NACK, 2 bytes written
    wbuf[0] = 8'h11; wbuf[1] = 8'h22; wbuf[2] = 8'h33; wbuf[3] = 8'h44;
    ebuf[0] = 8'h02;
    run_txn(2'b00, 20'h0010E, 8'd3, 1'b0, 1'b0, 4, 2'b01, 1);
    // Read straddling the top -> NACK, no data
    run_txn(2'b01, 20'h0010F, 8'd1, 1'b0, 1'b0, 0, 2'b01, 0);
    // In-range part of the straddling write landed
    ebuf[0] = 8'h11; ebuf[1] = 8'h22;
    run_txn(2'b01, 20'h0010E, 8'd1, 1'b0, 1'b0, 0, 2'b00, 2);
    // Deferred write must not touch the window
    wbuf[0] = 8'hFF;
    run_txn(2'b00, 20'h00100, 8'd0, 1'b1, 1'b0, 1, 2'b10, 0);
    ebuf[0] = 8'hA5;
    run_txn(2'b01, 20'h00100, 8'd0, 1'b0, 1'b0, 0, 2'b00, 1);
    // Unsupported command -> NACK
    run_txn(2'b10, 20'h00100, 8'd0, 1'b0, 1'b0, 0, 2'b01, 0);
    // Short write frame: len=2 but one byte -> NACK, count 01
    wbuf[0] = 8'h77;
    ebuf[0] = 8'h01;
    run_txn(2'b00, 20'h00102, 8'd2, 1'b0, 1'b0, 1, 2'b01, 1);
    // Read starting below the window -> NACK
    run_txn(2'b01, 20'h000FF, 8'd0, 1'b0, 1'b0, 0, 2'b01, 0);
    // Four-byte read across written and untouched bytes
    ebuf[0] = 8'hA5; ebuf[1] = 8'h3C; ebuf[2] = 8'h77; ebuf[3] = 8'h00;
    run_txn(2'b01, 20'h00100, 8'd3, 1'b0, 1'b0, 0, 2'b00, 4);
    // Stop coincident with header in IDLE is ignored; frame continues
    wbuf[0] = 8'h5A;
    run_txn(2'b00, 20'h00105, 8'd0, 1'b0, 1'b1, 1, 2'b00, 0);
    ebuf[0] = 8'h5A;
    run_txn(2'b01, 20'h00105, 8'd0, 1'b0, 1'b0, 0, 2'b00, 1);

    // Reset during TX_DATA of a len=7 read: two bytes out, then abandoned
    @(posedge clk);
    #1;
    req_hdr_vld = 1'b1;
    req_cmd     = 2'b01;
    req_address = 20'h00100;
    req_len     = 8'd7;
    @(posedge clk);
    #1;
    req_hdr_vld = 1'b0;
    req_stop    = 1'b1;
    s = cyc;
    push(0, 8'h00, s + DLY + 1);
    push(1, 8'hA5, s + DLY + 2);
    push(1, 8'h3C, s + DLY + 3);
    @(posedge clk);
    #1;
    req_stop = 1'b0;
    wait_until(s + DLY + 3);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    n_cmp++;
    if ({rsp_busy, rpl_tr_vld, rpl_ack, rpl_data_vld, rpl_data, rpl_done} !== 14'h0) begin
      n_err++;
      $display("FAIL mid_reset: got busy=%b tr=%b ack=%0d dv=%b d=%02h done=%b, required all 0",
               rsp_busy, rpl_tr_vld, rpl_ack, rpl_data_vld, rpl_data, rpl_done);
    end
    repeat (12) @(posedge clk);
    #1;
    // Window cleared by reset
    ebuf[0] = 8'h00; ebuf[1] = 8'h00;
    run_txn(2'b01, 20'h00100, 8'd1, 1'b0, 1'b0, 0, 2'b00, 2);
    ebuf[0] = 8'h00;
    run_txn(2'b01, 20'h00105, 8'd0, 1'b0, 1'b0, 0, 2'b00, 1);

    repeat (4) @(posedge clk);
    #1;
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_err++;
      $display("FAIL missing_events: got %0d outstanding, required 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
